// File: rtl/spi_regbank_burst.sv
// SPI slave register bank with burst (auto-increment) access.
//
// Purpose:
//   Synchronises the raw SPI pins and decodes frames of the form
//   {rw, addr} command byte followed by one or more REG_WIDTH-bit data words.
//   The address map holds NUM_CFG writable config registers followed by
//   NUM_STATUS read-only status registers; all other addresses read zero.
//   Supports all four SPI modes, latched per frame at CS fall.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   ena             when low, FSM and registers hold (synchronizers keep running)
//   spi_cs_n        raw chip select, active low
//   spi_clk         raw SPI clock
//   spi_mosi        raw MOSI
//   cpol, cpha      raw SPI mode select, latched at CS fall
//   spi_miso        MISO data
//   spi_miso_oe     high while the synchronised CS is asserted
//   config_regs     flattened config registers, reg 0 in the LSBs
//   status_regs     flattened status inputs, sampled at read load
//   cfg_wr_strobe   one-cycle pulse when a config write commits
//   cfg_wr_addr     index of the committed register, valid with the strobe
//   frame_err       one-cycle pulse when CS rises mid-byte or mid-word
module spi_regbank_burst #(
  parameter int unsigned          NUM_CFG    = 16,
  parameter int unsigned          NUM_STATUS = 8,
  parameter int unsigned          REG_WIDTH  = 8,
  parameter int unsigned          ADDR_W     = 7,
  parameter logic [REG_WIDTH-1:0] CFG_RESET  = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ena,
  input  logic                            spi_cs_n,
  input  logic                            spi_clk,
  input  logic                            spi_mosi,
  input  logic                            cpol,
  input  logic                            cpha,
  output logic                            spi_miso,
  output logic                            spi_miso_oe,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            cfg_wr_strobe,
  output logic [ADDR_W-1:0]               cfg_wr_addr,
  output logic                            frame_err
);

  localparam logic [5:0] LastDataBit = 6'(REG_WIDTH - 1);
  localparam logic [5:0] LastCmdBit  = 6'd7;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] cs_sync, sclk_sync, mosi_sync, cpol_sync, cpha_sync;
  logic       cs_prev, sclk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      cpol_sync <= 2'b00;
      cpha_sync <= 2'b00;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], spi_cs_n};
      sclk_sync <= {sclk_sync[0], spi_clk};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      cpol_sync <= {cpol_sync[0], cpol};
      cpha_sync <= {cpha_sync[0], cpha};
      cs_prev   <= cs_sync[1];
      sclk_prev <= sclk_sync[1];
    end
  end

  logic cs_s, sclk_s, mosi_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  assign cs_s      = cs_sync[1];
  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;

  // ---------------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  logic [5:0]             bit_cnt_q;
  logic [6:0]             cmd_sr_q;
  logic [REG_WIDTH-2:0]   data_sr_q;
  logic                   rw_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   cpol_q, cpha_q;
  logic [REG_WIDTH-1:0]   tx_sr_q;
  logic                   skip_q;
  logic                   miso_q, oe_q;
  logic                   strobe_q, frame_err_q;
  logic [ADDR_W-1:0]      wr_addr_q;
  logic [REG_WIDTH-1:0]   cfg_q [NUM_CFG];

  // Edge roles for the mode latched at CS fall.
  logic lead_e, trail_e, sample_e, shift_e;
  assign lead_e   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_e  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_e = cpha_q ? trail_e : lead_e;
  assign shift_e  = cpha_q ? lead_e : trail_e;

  logic [7:0]           cmd_byte;
  logic [ADDR_W-1:0]    cmd_addr, addr_inc, rd_addr;
  logic [REG_WIDTH-1:0] data_word, rd_word, ld_word;
  logic                 ld_rw, cmd_last, data_last;

  assign cmd_byte  = {cmd_sr_q, mosi_s};
  assign cmd_addr  = cmd_byte[ADDR_W-1:0];
  assign addr_inc  = addr_q + 1'b1;
  assign data_word = {data_sr_q, mosi_s};
  assign cmd_last  = (bit_cnt_q == LastCmdBit);
  assign data_last = (bit_cnt_q == LastDataBit);

  // The read load happens either at the end of the command byte (addressed by
  // the command itself) or at the end of a data word (next burst address).
  assign rd_addr = (state_q == StCmd) ? cmd_addr : addr_inc;
  assign ld_rw   = (state_q == StCmd) ? cmd_byte[7] : rw_q;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(NUM_CFG); i++) begin
      if (rd_addr == ADDR_W'(i)) rd_word = cfg_q[i];
    end
    for (int j = 0; j < int'(NUM_STATUS); j++) begin
      if (rd_addr == ADDR_W'(int'(NUM_CFG) + j)) begin
        rd_word = status_regs[j*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  // Write frames return zeros on MISO.
  assign ld_word = ld_rw ? '0 : rd_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      cmd_sr_q    <= '0;
      data_sr_q   <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      tx_sr_q     <= '0;
      skip_q      <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      strobe_q    <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < int'(NUM_CFG); i++) cfg_q[i] <= CFG_RESET;
    end else begin
      strobe_q    <= 1'b0;
      frame_err_q <= 1'b0;
      oe_q        <= ~cs_s;
      if (ena) begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q   <= StCmd;
              bit_cnt_q <= '0;
              cpol_q    <= cpol_sync[1];
              cpha_q    <= cpha_sync[1];
              tx_sr_q   <= '0;
              skip_q    <= 1'b0;
              miso_q    <= 1'b0;
            end
          end

          StCmd, StData: begin
            if (sample_e) begin
              if (state_q == StCmd) begin
                cmd_sr_q <= cmd_byte[6:0];
              end else begin
                data_sr_q <= data_word[REG_WIDTH-2:0];
              end
              if ((state_q == StCmd) ? cmd_last : data_last) begin
                bit_cnt_q <= '0;
                if (state_q == StCmd) begin
                  state_q <= StData;
                  rw_q    <= cmd_byte[7];
                  addr_q  <= cmd_addr;
                end else begin
                  addr_q <= addr_inc;
                  if (rw_q) begin
                    // Status and unmapped addresses never match and are dropped.
                    for (int i = 0; i < int'(NUM_CFG); i++) begin
                      if (addr_q == ADDR_W'(i)) begin
                        cfg_q[i]  <= data_word;
                        strobe_q  <= 1'b1;
                        wr_addr_q <= addr_q;
                      end
                    end
                  end
                end
                // cpha=0 puts the MSB out at once and must skip the shift edge
                // that trails the sample edge which caused the load.
                if (cpha_q) begin
                  tx_sr_q <= ld_word;
                end else begin
                  tx_sr_q <= {ld_word[REG_WIDTH-2:0], 1'b0};
                  miso_q  <= ld_word[REG_WIDTH-1];
                end
                skip_q <= ~cpha_q;
              end else begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
              end
            end else if (shift_e) begin
              if (skip_q) begin
                skip_q <= 1'b0;
              end else begin
                miso_q  <= tx_sr_q[REG_WIDTH-1];
                tx_sr_q <= {tx_sr_q[REG_WIDTH-2:0], 1'b0};
              end
            end

            if (cs_rise) begin
              state_q <= StIdle;
              miso_q  <= 1'b0;
              skip_q  <= 1'b0;
              // A bit sampled in the same cycle counts toward the byte/word.
              if (sample_e) begin
                frame_err_q <= (state_q == StCmd) ? ~cmd_last : ~data_last;
              end else begin
                frame_err_q <= (bit_cnt_q != 6'd0);
              end
            end
          end

          default: state_q <= StIdle;
        endcase
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_CFG); g++) begin : g_cfg_out
    assign config_regs[g*REG_WIDTH +: REG_WIDTH] = cfg_q[g];
  end

  assign spi_miso      = miso_q;
  assign spi_miso_oe   = oe_q;
  assign cfg_wr_strobe = strobe_q;
  assign cfg_wr_addr   = wr_addr_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_spi_regbank_burst.sv
// Self-checking bench for spi_regbank_burst (default parameters).
// A bit-banged SPI master drives frames in all four modes; expected MISO
// words and expected write commits are queued as stimulus is issued and
// compared when the DUT produces them.
module tb_spi_regbank_burst;

  localparam int W  = 8;
  localparam int NC = 16;

  logic          clk = 1'b0;
  logic          rst, ena, spi_cs_n, spi_clk, spi_mosi, cpol, cpha;
  logic          spi_miso, spi_miso_oe, cfg_wr_strobe, frame_err;
  logic [NC*W-1:0] config_regs;
  logic [8*W-1:0]  status_regs;
  logic [6:0]      cfg_wr_addr;

  spi_regbank_burst dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .spi_cs_n     (spi_cs_n),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .cpol         (cpol),
    .cpha         (cpha),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .config_regs  (config_regs),
    .status_regs  (status_regs),
    .cfg_wr_strobe(cfg_wr_strobe),
    .cfg_wr_addr  (cfg_wr_addr),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboards: expected MISO words, expected commits {addr[6:0], data[7:0]}.
  logic [7:0]  rx_q[$];
  logic [14:0] wr_q[$];
  logic [7:0]  exp_cfg[NC];
  logic [7:0]  tx_cmd;
  logic [7:0]  tx_words[8];
  int          strobe_cnt = 0;
  int          err_cnt    = 0;

  always @(negedge clk) begin
    logic [14:0] e;
    logic [6:0]  ea;
    if (frame_err) err_cnt++;
    if (cfg_wr_strobe) begin
      strobe_cnt++;
      check_val("strobe_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        e  = wr_q.pop_front();
        ea = e[14:8];
        check_val("wr_addr", cfg_wr_addr, ea);
        check_val("wr_data", config_regs[int'(ea)*W +: W], e[7:0]);
      end
    end
  end

  function automatic logic [NC*W-1:0] model_vec();
    logic [NC*W-1:0] v;
    for (int i = 0; i < NC; i++) v[i*W +: W] = exp_cfg[i];
    return v;
  endfunction

  // Sends the first nbits of {tx_cmd, tx_words...}; every complete data word
  // received on MISO is compared against the head of rx_q.
  task automatic spi_frame(input int mode, input int nbits);
    logic [7:0] rxw;
    logic       b;
    int         w, k;
    rxw = '0;
    @(negedge clk);
    cpol    = mode[1];
    cpha    = mode[0];
    spi_clk = mode[1];
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b0;
    #50;
    for (int i = 0; i < nbits; i++) begin
      k = 7 - (i % 8);
      w = (i - 8) / 8;
      b = (i < 8) ? tx_cmd[k] : tx_words[w][k];
      if (!cpha) begin
        spi_mosi = b;
        #50 spi_clk = ~spi_clk;
        if (i >= 8) rxw[k] = spi_miso;
        #50 spi_clk = ~spi_clk;
      end else begin
        spi_clk  = ~spi_clk;
        spi_mosi = b;
        #50 spi_clk = ~spi_clk;
        if (i >= 8) rxw[k] = spi_miso;
        #50;
      end
      if (i >= 8 && k == 0) begin
        check_val("rx_expected", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) check_val("miso_word", rxw, rx_q.pop_front());
      end
    end
    #50 spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  int s0, e0;

  initial begin
    rst = 1'b1; ena = 1'b1; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0;
    status_regs = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h5A, 8'h22, 8'h11};
    for (int i = 0; i < NC; i++) exp_cfg[i] = 8'h00;
    repeat (4) @(negedge clk);
    check_val("rst_cfg", config_regs, model_vec());
    check_val("rst_miso", spi_miso, 0);
    check_val("rst_oe", spi_miso_oe, 0);
    check_val("rst_strobe", cfg_wr_strobe, 0);
    check_val("rst_ferr", frame_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Mode 0 single write to reg 3.
    s0 = strobe_cnt;
    tx_cmd = 8'h83; tx_words[0] = 8'hA5;
    rx_q.push_back(8'h00);
    wr_q.push_back({7'd3, 8'hA5}); exp_cfg[3] = 8'hA5;
    spi_frame(0, 16);
    check_val("wr3_strobes", strobe_cnt - s0, 1);
    check_val("wr3_cfg", config_regs, model_vec());

    // Status reg 2 read in every mode.
    for (int m = 0; m < 4; m++) begin
      tx_cmd = 8'h12; tx_words[0] = 8'h00;
      rx_q.push_back(8'h5A);
      spi_frame(m, 16);
    end

    // Config reg 3 readback in mode 2; 2-word status burst in mode 3.
    tx_cmd = 8'h03; rx_q.push_back(8'hA5);
    spi_frame(2, 16);
    tx_cmd = 8'h11; rx_q.push_back(8'h22); rx_q.push_back(8'h5A);
    spi_frame(3, 24);

    // Burst write crossing into status space: third word dropped.
    s0 = strobe_cnt;
    tx_cmd = 8'h8E; tx_words[0] = 8'h11; tx_words[1] = 8'h22; tx_words[2] = 8'h33;
    for (int i = 0; i < 3; i++) rx_q.push_back(8'h00);
    wr_q.push_back({7'd14, 8'h11}); exp_cfg[14] = 8'h11;
    wr_q.push_back({7'd15, 8'h22}); exp_cfg[15] = 8'h22;
    spi_frame(1, 32);
    check_val("burst_strobes", strobe_cnt - s0, 2);
    check_val("burst_cfg", config_regs, model_vec());
    check_val("status_unchanged", status_regs[2*W +: W], 8'h5A);

    // Unmapped read with wrap to reg 0 (reg 0 given a non-reset value first).
    tx_cmd = 8'h80; tx_words[0] = 8'h77; rx_q.push_back(8'h00);
    wr_q.push_back({7'd0, 8'h77}); exp_cfg[0] = 8'h77;
    spi_frame(0, 16);
    tx_cmd = 8'h7F; rx_q.push_back(8'h00); rx_q.push_back(8'h77);
    spi_frame(0, 24);

    // Partial data word: frame error, no commit.
    s0 = strobe_cnt; e0 = err_cnt;
    tx_cmd = 8'h85; tx_words[0] = 8'hFF;
    spi_frame(0, 13);
    check_val("partial_ferr", err_cnt - e0, 1);
    check_val("partial_strobes", strobe_cnt - s0, 0);
    check_val("partial_cfg", config_regs, model_vec());

    // Partial command byte.
    e0 = err_cnt;
    tx_cmd = 8'h85;
    spi_frame(3, 3);
    check_val("partial_cmd_ferr", err_cnt - e0, 1);

    // Reset mid-burst; held until CS is released.
    tx_cmd = 8'h81; tx_words[0] = 8'h99; tx_words[1] = 8'h98; tx_words[2] = 8'h97;
    for (int i = 0; i < 3; i++) rx_q.push_back(8'h00);
    wr_q.push_back({7'd1, 8'h99});
    fork
      spi_frame(0, 32);
      begin
        #2000 rst = 1'b1;
      end
    join
    check_val("midrst_oe", spi_miso_oe, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NC; i++) exp_cfg[i] = 8'h00;
    repeat (4) @(negedge clk);
    check_val("midrst_cfg", config_regs, model_vec());
    check_val("midrst_miso", spi_miso, 0);
    check_val("midrst_wrq_empty", wr_q.size(), 0);

    // Fresh write after reset.
    s0 = strobe_cnt;
    tx_cmd = 8'h81; tx_words[0] = 8'h3C; rx_q.push_back(8'h00);
    wr_q.push_back({7'd1, 8'h3C}); exp_cfg[1] = 8'h3C;
    spi_frame(0, 16);
    check_val("post_rst_strobes", strobe_cnt - s0, 1);
    check_val("post_rst_cfg", config_regs, model_vec());

    check_val("rx_q_empty", rx_q.size(), 0);
    check_val("wr_q_empty", wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_regbank_burst.md
Name: spi_regbank_burst

Overview:
Parametrised SPI slave register bank, the next generation of our single-frame SPI register wrapper. It synchronises the raw SPI pins internally and supports all four SPI modes. It exposes NUM_CFG writable config registers and NUM_STATUS read-only status registers in one address map, with independent counts. It adds burst (auto-increment) access, a per-write commit strobe, and framing-error detection. It sits directly behind the top-level pin mapping and replaces the external synchronizers plus the previous wrapper.

Parameters:
NUM_CFG, 16, number of writable config registers (1..64)
NUM_STATUS, 8, number of read-only status registers (1..64, independent of NUM_CFG)
REG_WIDTH, 8, data word width in bits (8, 16 or 32)
ADDR_W, 7, address field width; NUM_CFG+NUM_STATUS <= 2**ADDR_W
CFG_RESET, 0, reset value loaded into every config register

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
ena  in  1  when 0, state holds and SPI edges are ignored
spi_cs_n  in  1  raw chip select, active low (asynchronous)
spi_clk  in  1  raw SPI clock (asynchronous)
spi_mosi  in  1  raw MOSI (asynchronous)
cpol  in  1  clock polarity (raw, synchronised internally)
cpha  in  1  clock phase (raw, synchronised internally)
spi_miso  out  1  MISO data
spi_miso_oe  out  1  high while CS is asserted (synchronised)
config_regs  out  NUM_CFG*REG_WIDTH  flattened config registers, reg 0 in LSBs
status_regs  in  NUM_STATUS*REG_WIDTH  flattened status inputs, sampled at read load
cfg_wr_strobe  out  1  one-cycle pulse when a config write commits
cfg_wr_addr  out  ADDR_W  index of the committed register, valid with strobe
frame_err  out  1  one-cycle pulse on bad frame termination

Behaviour:
- Reset values: config regs = CFG_RESET, spi_miso = 0, spi_miso_oe = 0, strobes = 0, FSM = IDLE, all synchronizer flops = 0 except the cs_n sync chain = 1.
- Every async input passes through 2-flop synchronizers. SPI clock frequency must be <= clk/8.
- Edges are detected from the synchronised spi_clk against its previous value.
- Leading edge is rising when cpol=0 and falling when cpol=1.
- Sample edge = leading if cpha=0, trailing if cpha=1. Shift edge = the other edge.
- cpol and cpha are latched at the CS falling edge and held constant for the frame.
- Frame format, MSB first:
  - command byte {rw, addr[ADDR_W-1:0]}, zero-padded at the MSB side when ADDR_W<7; rw=1 is write.
  - then one or more REG_WIDTH-bit data words.
- FSM states:
  - IDLE: on CS fall, go to CMD and clear the bit counter.
  - CMD: after 8 sample edges, latch rw and addr, go to DATA.
  - DATA: each REG_WIDTH sample edges completes a word; addr increments, wrapping 2**ADDR_W-1 -> 0.
  - CS rise from any state returns to IDLE.
- Address map:
  - 0..NUM_CFG-1 = config.
  - NUM_CFG..NUM_CFG+NUM_STATUS-1 = status.
  - All other addresses read 0; writes to status or unmapped addresses are dropped with no strobe.
- Write commit:
  - The register updates on the clk cycle after the last data bit's sample edge is detected.
  - cfg_wr_strobe is asserted in that same cycle, with cfg_wr_addr = the register index.
- Read:
  - The read shift register loads the addressed word in the cycle the command's 8th bit (or the previous word's last bit) is sampled. Status is sampled at that point.
  - cpha=0: the MSB is driven immediately at load; following bits change on shift edges.
  - cpha=1: each bit is driven on its shift edge.
  - During CMD, spi_miso = 0.
  - A write frame returns 0 on MISO.
- frame_err pulses for one cycle when CS rises in CMD with 1..7 bits received, or in DATA with a partial word. The partial word is discarded and no strobe is issued.
- CS rising in the same cycle as the final sample edge: the word completes and commits; no frame_err.
- ena=0: the FSM and registers hold, but the synchronizers keep running.
- rst mid-frame: immediate return to reset values; the frame is abandoned until the next CS fall.

Test Plan:
- Mode 0, write cmd 0x83 (write, addr 3), data 0xA5 -> config reg 3 = 0xA5; cfg_wr_strobe pulses once with cfg_wr_addr=3; other regs stay CFG_RESET.
- Modes 1/2/3 with NUM_CFG=16, NUM_STATUS=8, status reg 2 = 0x5A: read cmd 0x12 (addr 18 = status 2) -> MISO shifts out 0x5A in every mode.
- Burst write cmd 0x8E with data 0x11, 0x22, 0x33 -> regs 14=0x11, 15=0x22; third word goes to addr 16 (status) and is dropped; exactly two strobes.
- Read of unmapped addr 0x7F in a 2-word burst -> first word 0x00; address wraps to 0, second word = config reg 0.
- CS released after 5 bits of a data word -> frame_err pulses once; target register unchanged; no strobe.
- rst asserted mid-burst, then released -> all regs = CFG_RESET, miso_oe=0; a fresh write to reg 1 = 0x3C succeeds.
